// File: rtl/avalon_keycode_fifo.sv
// avalon_keycode_fifo
//  Avalon-MM slave keycode port. The CPU writes keycodes to DATA. Each write is
//  pushed into a DEPTH-entry FIFO, and fabric logic drains that FIFO over a
//  valid/ready stream. out_port mirrors the last keycode written, for legacy
//  consumers.
// Ports
//  clk, reset_n          system clock, async active-low reset
//  address, chipselect,  Avalon-MM slave interface (read latency 0)
//  write_n, writedata,
//  readdata
//  out_port              last keycode written to DATA
//  kc_data, kc_valid,    FIFO head stream towards the consumer
//  kc_ready
//  irq                   level interrupt: overflow & irq_en
module avalon_keycode_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] kc_data,
    output logic              kc_valid,
    input  logic              kc_ready,
    output logic              irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              irq_en;

    logic [PTR_W-1:0]  rd_ptr_n, wr_ptr_n, rd_ptr_inc;
    logic [CNT_W-1:0]  count_n;
    logic [DATA_W-1:0] out_port_n, kc_data_n, wdata;
    logic              kc_valid_n, overflow_n, irq_en_n, irq_n;
    logic              wr, flush, push, pop, full, push_acc;

    // Every writedata bit is referenced so partial use does not trip lint.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // Next-state logic for pointers, occupancy, head register and control bits.
    always_comb begin
        wr         = chipselect & ~write_n;
        flush      = wr & (address == ADDR_CTRL) & writedata[1];
        push       = wr & (address == ADDR_DATA) & ~flush;
        pop        = kc_valid & kc_ready & ~flush;
        full       = (count == CNT_W'(DEPTH));
        push_acc   = push & (~full | pop);
        wdata      = writedata[DATA_W-1:0];
        rd_ptr_inc = rd_ptr + PTR_W'(1);

        rd_ptr_n   = rd_ptr;
        wr_ptr_n   = wr_ptr;
        count_n    = count;
        out_port_n = out_port;
        kc_data_n  = kc_data;
        overflow_n = overflow;
        irq_en_n   = irq_en;

        if (push) begin
            out_port_n = wdata;
        end
        if (push_acc) begin
            wr_ptr_n = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_n = rd_ptr_inc;
        end
        case ({push_acc, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase

        // Head register: refilled from the next slot on a pop, or straight
        // from writedata when the pushed entry becomes the new head.
        if (pop) begin
            if (count > CNT_W'(1)) begin
                kc_data_n = mem[rd_ptr_inc];
            end else if (push_acc) begin
                kc_data_n = wdata;
            end
        end else if (push_acc && (count == '0)) begin
            kc_data_n = wdata;
        end

        if (flush) begin
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            count_n  = '0;
        end

        if (wr && (address == ADDR_CTRL)) begin
            irq_en_n = writedata[0];
        end
        // Clear first so a simultaneous overflow wins.
        if (wr && (address == ADDR_STATUS) && writedata[18]) begin
            overflow_n = 1'b0;
        end
        if (push && !push_acc) begin
            overflow_n = 1'b1;
        end

        kc_valid_n = (count_n != '0);
        irq_n      = overflow_n & irq_en_n;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            out_port <= '0;
            kc_data  <= '0;
            kc_valid <= 1'b0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr_n;
            wr_ptr   <= wr_ptr_n;
            count    <= count_n;
            out_port <= out_port_n;
            kc_data  <= kc_data_n;
            kc_valid <= kc_valid_n;
            overflow <= overflow_n;
            irq_en   <= irq_en_n;
            irq      <= irq_n;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Zero-latency register readback.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[DATA_W-1:0] = out_port;
            ADDR_STATUS: begin
                readdata[CNT_W-1:0] = count;
                readdata[16]        = (count == '0);
                readdata[17]        = full;
                readdata[18]        = overflow;
            end
            ADDR_CTRL: readdata[0] = irq_en;
            default:   readdata = '0;
        endcase
    end

endmodule
